// File: rtl/hls_run_ctrl_if.sv
// Host/kernel signal bundle for hls_run_ctrl.
// The slave modport is the controller; the master modport is the host plus kernel side.
interface hls_run_ctrl_if #(
    parameter int RESULT_W = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                k_reset;
    logic                k_start;
    logic                k_finished;
    logic [RESULT_W-1:0] k_return_val;
    logic                res_valid;
    logic                res_ready;
    logic [RESULT_W-1:0] res_data;
    logic [31:0]         res_cycles;
    logic                res_timeout;
    logic [15:0]         run_count;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        input  k_reset,
        input  k_start,
        output k_finished,
        output k_return_val,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_cycles,
        input  res_timeout,
        input  run_count
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        output k_reset,
        output k_start,
        input  k_finished,
        input  k_return_val,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_cycles,
        output res_timeout,
        output run_count
    );
endinterface

// File: rtl/hls_run_ctrl.sv
// Run controller for an HLS kernel: reset, start, wait for finish, hand the result to the host.
// Define HLS_RUN_CTRL_TIMEOUT_EN to abort runs that exceed TIMEOUT_CYCLES in WAIT.
module hls_run_ctrl #(
    parameter int RESULT_W       = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    hls_run_ctrl_if.slave bus
);

`ifdef HLS_RUN_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        KRST,
        KSTART,
        WAIT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         cycle_cnt_q, cycle_cnt_d;
    logic [31:0]         cnt_inc;
    logic [RESULT_W-1:0] res_data_q, res_data_d;
    logic [31:0]         res_cycles_q, res_cycles_d;
    logic                res_timeout_q, res_timeout_d;
    logic [15:0]         run_count_q, run_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cycle_cnt_q   <= '0;
            res_data_q    <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
            run_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cycle_cnt_q   <= cycle_cnt_d;
            res_data_q    <= res_data_d;
            res_cycles_q  <= res_cycles_d;
            res_timeout_q <= res_timeout_d;
            run_count_q   <= run_count_d;
        end
    end

    // cnt_inc counts the current WAIT cycle too, so a finish seen on the Nth WAIT cycle reports N.
    always_comb begin
        state_d       = state_q;
        cycle_cnt_d   = cycle_cnt_q;
        res_data_d    = res_data_q;
        res_cycles_d  = res_cycles_q;
        res_timeout_d = res_timeout_q;
        run_count_d   = run_count_q;
        cnt_inc       = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d     = KRST;
                    cycle_cnt_d = '0;
                end
            end
            KRST:   state_d = KSTART;
            KSTART: state_d = WAIT;
            WAIT: begin
                cycle_cnt_d = cnt_inc;
                if (bus.k_finished) begin
                    res_data_d    = bus.k_return_val;
                    res_cycles_d  = cnt_inc;
                    res_timeout_d = 1'b0;
                    state_d       = DONE;
                end else if (TIMEOUT_EN && (cnt_inc >= TIMEOUT_LIMIT)) begin
                    res_data_d    = '0;
                    res_cycles_d  = TIMEOUT_LIMIT;
                    res_timeout_d = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d     = IDLE;
                    run_count_d = run_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The kernel is held in reset whenever the controller is, not only during KRST.
    assign bus.k_reset     = reset | (state_q == KRST);
    assign bus.k_start     = (state_q == KSTART);
    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.res_data    = res_data_q;
    assign bus.res_cycles  = res_cycles_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.run_count   = run_count_q;

endmodule

// File: tb/tb_hls_run_ctrl.sv
// Testbench for hls_run_ctrl: directed and randomized kernel runs against a run-level model.
// Timeout scenarios are exercised only when HLS_RUN_CTRL_TIMEOUT_EN is defined.
module tb_hls_run_ctrl;

    localparam int RESULT_W = 32;
    localparam int TO_CYCLES = 8;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;
    int   exp_run_count;
    logic [31:0] exp_data;
    logic [31:0] exp_cycles;

    hls_run_ctrl_if #(.RESULT_W(RESULT_W)) bus ();

    hls_run_ctrl #(
        .RESULT_W      (RESULT_W),
        .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One complete run: latency is the WAIT cycle on which the kernel raises finish;
    // the previous run's finish flag stays high through KRST/KSTART to model a stale kernel.
    task automatic applyStimulus(input logic [31:0] result, input int latency, input int ready_delay);
        int  lat_eff;
        bit  exp_to;
        lat_eff = latency;
        exp_to  = 1'b0;
`ifdef HLS_RUN_CTRL_TIMEOUT_EN
        if (latency > TO_CYCLES) begin
            lat_eff = TO_CYCLES;
            exp_to  = 1'b1;
        end
`endif
        bus.cmd_valid = 1'b1;
        checkOutput("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        checkOutput("krst_k_reset", 32'(bus.k_reset), 32'd1);
        checkOutput("krst_k_start", 32'(bus.k_start), 32'd0);
        checkOutput("krst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        checkOutput("kstart_k_start", 32'(bus.k_start), 32'd1);
        checkOutput("kstart_k_reset", 32'(bus.k_reset), 32'd0);
        tick();
        bus.k_finished   = 1'b0;
        bus.k_return_val = $urandom();
        checkOutput("wait_k_start", 32'(bus.k_start), 32'd0);
        for (int i = 1; i < lat_eff; i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            tick();
            bus.k_return_val = $urandom();
            checkOutput("wait_res_valid", 32'(bus.res_valid), 32'd0);
            checkOutput("wait_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        if (!exp_to) begin
            bus.k_finished   = 1'b1;
            bus.k_return_val = result;
        end
        if (ready_delay == 0) bus.res_ready = 1'b1;
        tick();
        exp_data   = exp_to ? 32'd0 : result;
        exp_cycles = 32'(lat_eff);
        for (int j = 0; j < ready_delay; j++) begin
            checkOutput("done_res_valid_hold", 32'(bus.res_valid), 32'd1);
            checkOutput("done_res_data_hold", bus.res_data, exp_data);
            checkOutput("done_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            tick();
        end
        bus.res_ready = 1'b1;
        checkOutput("done_res_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("done_res_data", bus.res_data, exp_data);
        checkOutput("done_res_cycles", bus.res_cycles, exp_cycles);
        checkOutput("done_res_timeout", 32'(bus.res_timeout), 32'(exp_to));
        tick();
        bus.res_ready = 1'b0;
        exp_run_count = (exp_run_count + 1) % 65536;
        checkOutput("idle_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("idle_run_count", 32'(bus.run_count), 32'(exp_run_count));
        checkOutput("idle_res_data_kept", bus.res_data, exp_data);
        checkOutput("idle_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        n_compared       = 0;
        n_mismatched     = 0;
        exp_run_count    = 0;
        reset            = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.k_finished   = 1'b0;
        bus.k_return_val = '0;
        bus.res_ready    = 1'b0;
        repeat (3) tick();
        checkOutput("rst_k_reset", 32'(bus.k_reset), 32'd1);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_k_start", 32'(bus.k_start), 32'd0);
        checkOutput("rst_res_data", bus.res_data, 32'd0);
        checkOutput("rst_res_cycles", bus.res_cycles, 32'd0);
        checkOutput("rst_res_timeout", 32'(bus.res_timeout), 32'd0);
        checkOutput("rst_run_count", 32'(bus.run_count), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_k_reset", 32'(bus.k_reset), 32'd0);

        applyStimulus(32'd6, 6, 0);
        applyStimulus(32'd6, 6, 10);
        applyStimulus(32'h1234, 3, 1);

        for (int n = 0; n < 12; n++) begin
`ifdef HLS_RUN_CTRL_TIMEOUT_EN
            applyStimulus($urandom(), int'($urandom_range(1, TO_CYCLES - 1)), int'($urandom_range(0, 4)));
`else
            applyStimulus($urandom(), int'($urandom_range(1, 40)), int'($urandom_range(0, 4)));
`endif
        end

        // Reset in the middle of WAIT must drop the run entirely.
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        bus.k_finished = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checkOutput("midrun_rst_k_reset", 32'(bus.k_reset), 32'd1);
        tick();
        exp_run_count = 0;
        checkOutput("midrun_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("midrun_rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("midrun_rst_run_count", 32'(bus.run_count), 32'd0);
        checkOutput("midrun_rst_res_data", bus.res_data, 32'd0);
        reset = 1'b0;
        bus.k_finished = 1'b1;
        repeat (4) begin
            tick();
            checkOutput("post_rst_no_result", 32'(bus.res_valid), 32'd0);
            checkOutput("post_rst_idle", 32'(bus.cmd_ready), 32'd1);
        end
        applyStimulus(32'hCAFE_F00D, 4, 2);

`ifdef HLS_RUN_CTRL_TIMEOUT_EN
        applyStimulus(32'hDEAD_BEEF, 20, 1);
        applyStimulus(32'h55, TO_CYCLES, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
